// File: rtl/sync_fifo_mem_if.sv
// Producer/consumer bus for sync_fifo_mem: push/pop requests, read data, status and error flags.
interface sync_fifo_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PTR_WIDTH:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with storage, wrap-bit pointers, occupancy flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sync_fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 2
) (
    input  logic            clock,
    input  logic            reset,
    sync_fifo_mem_if.slave  bus
);
    localparam logic [PTR_WIDTH:0] PTR_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH+1)'(AFULL_LVL);
    localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH+1)'(AEMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_WIDTH:0]    wptr_r;
    logic [PTR_WIDTH:0]    rptr_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic [PTR_WIDTH:0]    count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Occupancy and acceptance decode from the registered pointers.
    always_comb begin
        count_s  = wptr_r - rptr_r;
        empty_s  = (wptr_r == rptr_r);
        full_s   = (wptr_r[PTR_WIDTH] != rptr_r[PTR_WIDTH]) &&
                   (wptr_r[PTR_WIDTH-1:0] == rptr_r[PTR_WIDTH-1:0]);
        wr_acc_s = bus.w_en & ~full_s;
        rd_acc_s = bus.r_en & ~empty_s;
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_acc_s && !reset) begin
            mem_r[wptr_r[PTR_WIDTH-1:0]] <= bus.data_in;
        end
    end

    // Pointer advance and sticky error capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_r      <= '0;
            rptr_r      <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            if (bus.w_en && full_s) begin
                overflow_r <= 1'b1;
            end
            if (bus.r_en && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.count        = count_s;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_s >= AFULL_C);
    assign bus.almost_empty = (count_s <= AEMPTY_C);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

`ifdef FIFO_FWFT_EN
    // Head word falls through whenever the FIFO holds data.
    assign bus.data_out = empty_s ? '0 : mem_r[rptr_r[PTR_WIDTH-1:0]];
    assign bus.r_valid  = ~empty_s;
`else
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  r_valid_r;

    // Registered read port: capture the head word on an accepted pop, hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_r <= '0;
            r_valid_r  <= 1'b0;
        end else begin
            r_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                data_out_r <= mem_r[rptr_r[PTR_WIDTH-1:0]];
            end
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.r_valid  = r_valid_r;
`endif
endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed, table-driven bench for sync_fifo_mem (DEPTH=8, AFULL=6, AEMPTY=2).
module tb_sync_fifo_mem;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sync_fifo_mem_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) bus ();

    sync_fifo_mem #(
        .DEPTH(8), .DATA_WIDTH(8), .PTR_WIDTH(3), .AFULL_LVL(6), .AEMPTY_LVL(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic       rv;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] status_now();
        return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                bus.overflow, bus.underflow};
    endfunction

    task automatic check_st(input string name, input logic [3:0] cnt, input logic full,
                            input logic empty, input logic af, input logic ae,
                            input logic ovf, input logic udf);
        logic [9:0] exp;
        exp = {cnt, full, empty, af, ae, ovf, udf};
        check(name, {22'd0, status_now()}, {22'd0, exp});
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = d;
        @(posedge clock);
        #1;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Pop one word and check it: before the edge in FWFT, after the edge otherwise.
    task automatic pop_check(input string name, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
        check({name, "_dout"}, {24'd0, bus.data_out}, {24'd0, exp});
        check({name, "_rv"}, {31'd0, bus.r_valid}, 32'd1);
        step(1'b0, 1'b1, 8'h00);
`else
        step(1'b0, 1'b1, 8'h00);
        check({name, "_dout"}, {24'd0, bus.data_out}, {24'd0, exp});
        check({name, "_rv"}, {31'd0, bus.r_valid}, 32'd1);
`endif
    endtask

    initial begin
        logic [7:0] d;
        bus.w_en = 1'b0; bus.r_en = 1'b0; bus.data_in = 8'h00;

        //          w     r     din    cnt   full  empty af    ae    ovf   udf   rv    dout
        vecs[0]  = '{1'b1, 1'b0, 8'h11, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h12, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h13, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'h14, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h15, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 8'h16, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 8'h17, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'h18, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 8'h99, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h13};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h14};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h15};
        vecs[14] = '{1'b0, 1'b1, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h16};
        vecs[15] = '{1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h17};
        vecs[16] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h18};
        vecs[17] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h18};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h18};

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_st("reset_status", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_rv", {31'd0, bus.r_valid}, 32'd0);
        check("reset_dout", {24'd0, bus.data_out}, 32'd0);

        // Fill, overflow, drain and underflow from the table.
        for (int i = 0; i < 19; i++) begin
`ifdef FIFO_FWFT_EN
            if (vecs[i].r && !vecs[i].empty) begin
                check($sformatf("vec%0d_fwft_head", i), {24'd0, bus.data_out}, {24'd0, vecs[i].dout});
            end
`endif
            step(vecs[i].w, vecs[i].r, vecs[i].din);
            check_st($sformatf("vec%0d_status", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
                     vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf);
`ifdef FIFO_FWFT_EN
            check($sformatf("vec%0d_rv", i), {31'd0, bus.r_valid}, {31'd0, ~vecs[i].empty});
            if (vecs[i].empty) begin
                check($sformatf("vec%0d_dout0", i), {24'd0, bus.data_out}, 32'd0);
            end
`else
            check($sformatf("vec%0d_rv", i), {31'd0, bus.r_valid}, {31'd0, vecs[i].rv});
            if (vecs[i].r) begin
                check($sformatf("vec%0d_dout", i), {24'd0, bus.data_out}, {24'd0, vecs[i].dout});
            end
`endif
        end

        // Wrap-around: pointers start at 8, three rounds of 5 cross index 7 -> 0.
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int k = 0; k < 5; k++) begin
                d = 8'(8'h20 + 8'(rnd * 16) + 8'(k));
                step(1'b1, 1'b0, d);
            end
            check_st($sformatf("wrap%0d_filled", rnd), 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            for (int k = 0; k < 5; k++) begin
                d = 8'(8'h20 + 8'(rnd * 16) + 8'(k));
                pop_check($sformatf("wrap%0d_%0d", rnd, k), d);
            end
            check_st($sformatf("wrap%0d_drained", rnd), 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        end

        // Simultaneous push/pop on an empty FIFO: write wins, underflow sets.
        do_reset();
        step(1'b1, 1'b1, 8'h3C);
        check_st("simul_empty", 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pop_check("simul_empty_rd", 8'h3C);

        // Simultaneous push/pop on a full FIFO: read wins, overflow sets.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 8'(8'h40 + 8'(k)));
        end
        check_st("refill_full", 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hEE);
        check_st("simul_full", 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        pop_check("after_full_rd0", 8'h41);
        pop_check("after_full_rd1", 8'h42);
        check_st("pre_reset_5", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-burst with both requests active.
        bus.w_en = 1'b1; bus.r_en = 1'b1; bus.data_in = 8'h77;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0; bus.w_en = 1'b0; bus.r_en = 1'b0;
        check_st("midreset_status", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midreset_rv", {31'd0, bus.r_valid}, 32'd0);
        check("midreset_dout", {24'd0, bus.data_out}, 32'd0);

        // Simultaneous push/pop at count 3 leaves count unchanged.
        step(1'b1, 1'b0, 8'h51);
        step(1'b1, 1'b0, 8'h52);
        step(1'b1, 1'b0, 8'h53);
        step(1'b1, 1'b1, 8'h54);
        check_st("simul_mid", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check("simul_mid_rd", 8'h52);

`ifdef FIFO_FWFT_EN
        // Fall-through: a word written into an empty FIFO shows without r_en.
        do_reset();
        step(1'b1, 1'b0, 8'hA5);
        check("fwft_dout", {24'd0, bus.data_out}, 32'h0000_00A5);
        check("fwft_rv", {31'd0, bus.r_valid}, 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check_st("fwft_popped", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fwft_dout_empty", {24'd0, bus.data_out}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_mem.md
# sync_fifo_mem

Single-clock FIFO with storage, pointers, status flags and error flags in one block. It generalises the dual-port FIFO storage array: the write/read pointer logic, full/empty generation and occupancy count are inside the block. Configurable depth, width and almost-full/almost-empty thresholds. It sits between same-clock producer and consumer stages wherever rate smoothing is needed without a clock-domain crossing.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2
- DATA_WIDTH, 8, word width in bits
- PTR_WIDTH, 3, log2(DEPTH); pointers are PTR_WIDTH+1 bits
- AFULL_LVL, 6, almost_full asserts when count ≥ AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserts when count ≤ AEMPTY_LVL

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request (pop)
- data_out  out  DATA_WIDTH  read data
- r_valid  out  1  data_out holds a valid popped or head word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LVL
- almost_empty  out  1  count ≤ AEMPTY_LVL
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty

## Operation
- Binary pointers wptr, rptr are PTR_WIDTH+1 bits. Storage is addressed by the low PTR_WIDTH bits, and the MSB is the wrap bit.
- empty = (wptr == rptr). full = MSBs differ and low bits equal. count = wptr − rptr, modulo 2^(PTR_WIDTH+1).
- Write accepted = w_en & !full. Accepted write stores mem[wptr] ← data_in and increments wptr.
- Read accepted = r_en & !empty. Accepted read increments rptr.
- Flags are evaluated on the state at the start of the cycle:
  - Full plus simultaneous w_en/r_en: the read is accepted and the write is rejected. Count becomes DEPTH−1 and overflow sets.
  - Empty plus simultaneous w_en/r_en: the write is accepted and the read is rejected. Count becomes 1 and underflow sets.
  - Neither full nor empty, both requested: both are accepted and count is unchanged.
- Pointer wrap is natural modulo 2^(PTR_WIDTH+1). There is no special-casing at DEPTH−1 → 0.
- overflow and underflow clear only on reset.
- Reset values: wptr = rptr = 0, empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0, r_valid = 0, data_out = 0.
- The storage array is not reset. Reset asserted mid-operation discards all contents on that edge.

## Timing
- Flags and count are combinational from registered pointers. They reflect an accepted operation in the cycle after its clock edge.
- A write into an empty FIFO: empty deasserts one cycle after the write edge.
- Standard mode (macro undefined):
  - data_out is registered and loads mem[rptr] on the edge of an accepted read. Otherwise it holds.
  - r_valid is high for exactly the cycle after an accepted read.
  - Read latency is 1 cycle.
- FWFT mode: see Configuration.
- Back-to-back reads or writes at one per cycle are sustained indefinitely when not blocked by flags.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - data_out = mem[rptr] combinationally whenever !empty, and 0 when empty.
  - r_valid = !empty.
  - r_en acts as an acknowledge that pops the shown word. The next word appears in the following cycle.
  - A word written into an empty FIFO is visible on data_out one cycle after the write edge.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as described in Timing.
- Flags, count and error behaviour are identical in both modes.

## Test plan
- Reset, then write 0x11..0x18 on 8 consecutive cycles (DEPTH=8):
  - full = 1 and count = 8 after the last edge.
  - almost_full first = 1 when count = 6.
  - A 9th write with 0x99 leaves count = 8 and sets overflow. 0x99 is never read back.
- From full, read 8 times:
  - Data comes out in order 0x11..0x18. In standard mode each word is on data_out with r_valid = 1 the cycle after its r_en.
  - Then empty = 1. A further r_en sets underflow, and data_out holds 0x18 (standard) or reads 0 (FWFT).
- Wrap-around: write 5 and read 5, three times, checking data order each round. count returns to 0 and pointers cross index 7 → 0 with no data loss.
- Simultaneous w_en/r_en:
  - At count = 3, count stays 3.
  - At full, count → 7 and overflow sets.
  - At empty, count → 1, underflow sets, and the written word is readable next.
- Reset asserted at count = 5 mid-burst: on that edge count = 0, empty = 1, overflow = underflow = 0, r_valid = 0, and data_out = 0.
- FWFT build: write 0xA5 into an empty FIFO. data_out = 0xA5 with r_valid = 1 in the next cycle with no r_en. After r_en pops it, empty = 1.
